// File: rtl/cambuf_mcu_reader.sv
// Reads completed 8-line strips from the camera line buffer and emits 8x8
// YUV444 block rows in MCU order (Y, U, V per column) over valid/ready.
module cambuf_mcu_reader #(
  parameter int LUMA_LINE_WORDS = 240,
  parameter int AW              = 14,
  parameter int U_BASE          = LUMA_LINE_WORDS * 16,
  parameter int V_BASE          = LUMA_LINE_WORDS * 32
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          cam_pic_start_f,
  input  logic          camfifo_o_f,
  input  logic [12:0]   PicWidth_i,
  output logic          cena_cam,
  output logic [AW-1:0] aa_cam,
  input  logic [63:0]   qa_cam,
  output logic          blk_valid,
  input  logic          blk_ready,
  output logic [63:0]   blk_data,
  output logic [2:0]    blk_row,
  output logic [1:0]    blk_comp,
  output logic          blk_first,
  output logic          blk_last,
  output logic          strip_busy,
  output logic          strip_ovf
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

  typedef struct packed {
    logic [2:0] row;
    logic [1:0] comp;
    logic       first;
    logic       last;
  } meta_t;

  typedef struct packed {
    logic [63:0] data;
    meta_t       meta;
  } row_t;

  state_e      state_q, state_d;
  logic        half_q, half_d;
  logic        pending_q, pending_d;
  logic        force0_q, force0_d;
  logic [10:0] nblk_q, nblk_d;
  logic [10:0] m_q, m_d;
  logic [1:0]  c_q, c_d;
  logic [2:0]  r_q, r_d;
  logic        busy_q, busy_d;
  logic        ovf_q, ovf_d;
  logic        rd_q;
  meta_t       meta_q;
  row_t        fifo_q [2];
  logic        rd_ptr_q, wr_ptr_q;
  logic [1:0]  cnt_q;

  logic        pop, push, issue, last_rd, start, consume, drain_exit;
  logic        fifo_new, kept;
  logic [1:0]  credit_use;
  logic [10:0] nblk_calc;
  meta_t       meta_cur;
  row_t        head;
  logic [AW-1:0] base;

  assign head       = fifo_q[rd_ptr_q];
  assign blk_valid  = (cnt_q != 2'd0);
  assign blk_data   = head.data;
  assign blk_row    = head.meta.row;
  assign blk_comp   = head.meta.comp;
  assign blk_first  = head.meta.first;
  assign blk_last   = head.meta.last;
  assign strip_busy = busy_q;
  assign strip_ovf  = ovf_q;

  assign pop  = blk_valid & blk_ready;
  assign push = rd_q;

  // Entries freed by this cycle's pop count as credit, so with blk_ready high a
  // read can issue every cycle despite the two-cycle issue-to-visible latency.
  assign credit_use = (cnt_q - {1'b0, pop}) + {1'b0, rd_q};
  assign issue      = (state_q == S_RUN) && (credit_use < 2'd2);
  assign cena_cam   = ~issue;

  assign nblk_calc = 11'((14'(PicWidth_i) + 14'd7) >> 3);
  assign last_rd   = (m_q == nblk_q - 11'd1) && (c_q == 2'd2) && (r_q == 3'd7);

  always_comb begin
    meta_cur.row   = r_q;
    meta_cur.comp  = c_q;
    meta_cur.first = (m_q == 11'd0) && (c_q == 2'd0) && (r_q == 3'd0);
    meta_cur.last  = last_rd;
  end

  always_comb begin
    case (c_q)
      2'd1:    base = AW'(U_BASE);
      2'd2:    base = AW'(V_BASE);
      default: base = '0;
    endcase
    aa_cam = base + AW'(LUMA_LINE_WORDS) * AW'({half_q, r_q}) + AW'(m_q);
  end

  always_comb begin
    state_d    = state_q;
    half_d     = half_q;
    pending_d  = pending_q;
    force0_d   = force0_q;
    nblk_d     = nblk_q;
    m_d        = m_q;
    c_d        = c_q;
    r_d        = r_q;
    busy_d     = busy_q;
    ovf_d      = 1'b0;
    start      = 1'b0;
    consume    = 1'b0;
    drain_exit = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (camfifo_o_f || pending_q) begin
          start   = 1'b1;
          consume = pending_q;
        end
      end
      S_RUN: begin
        if (issue && last_rd) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (cnt_q == 2'd0 && !rd_q) begin
          drain_exit = 1'b1;
          half_d     = force0_q ? 1'b0 : ~half_q;
          force0_d   = 1'b0;
          if (pending_q) begin
            start   = 1'b1;
            consume = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (cam_pic_start_f) begin
      if (state_q == S_IDLE || drain_exit) half_d = 1'b0;
      else                                 force0_d = 1'b1;
    end

    // A strip-ready pulse that did not start a strip itself must be queued.
    fifo_new  = camfifo_o_f && !(state_q == S_IDLE && !pending_q);
    kept      = pending_q && !consume && !cam_pic_start_f;
    pending_d = kept | fifo_new;
    ovf_d     = fifo_new && kept;

    if (pop && head.meta.last) busy_d = 1'b0;

    if (start) begin
      state_d = S_RUN;
      nblk_d  = nblk_calc;
      m_d     = '0;
      c_d     = '0;
      r_d     = '0;
      busy_d  = 1'b1;
    end else if (issue) begin
      if (r_q == 3'd7) begin
        r_d = '0;
        if (c_q == 2'd2) begin
          c_d = '0;
          m_d = m_q + 11'd1;
        end else begin
          c_d = c_q + 2'd1;
        end
      end else begin
        r_d = r_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      half_q    <= 1'b0;
      pending_q <= 1'b0;
      force0_q  <= 1'b0;
      nblk_q    <= '0;
      m_q       <= '0;
      c_q       <= '0;
      r_q       <= '0;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
      rd_q      <= 1'b0;
      meta_q    <= '0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      half_q    <= half_d;
      pending_q <= pending_d;
      force0_q  <= force0_d;
      nblk_q    <= nblk_d;
      m_q       <= m_d;
      c_q       <= c_d;
      r_q       <= r_d;
      busy_q    <= busy_d;
      ovf_q     <= ovf_d;
      rd_q      <= issue;
      if (issue) meta_q <= meta_cur;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      cnt_q     <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // Read data is captured on its return cycle together with the metadata of
  // the read that produced it.
  for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        fifo_q[gi] <= '0;
      end else if (push && wr_ptr_q == 1'(gi)) begin
        fifo_q[gi] <= {qa_cam, meta_q};
      end
    end
  end

endmodule
